// File: rtl/if_stage.sv
// Instruction-fetch stage.
// Issues sequential word-aligned fetches on a valid/grant memory port, keeps
// the PCs of granted-but-unanswered requests in a small queue, parks returned
// instructions in a buffer while decode is stalled, and drives the registered
// IF_ID bundle. An EX redirect flushes the buffer, marks every in-flight
// request stale so its late response is discarded, and restarts fetch at the
// target.
module if_stage #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          FIFO_DEPTH      = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        ID_stall,
    input  logic        EX_redirect,
    input  logic [31:0] EX_target,
    output logic [31:0] IF_ID_pc,
    output logic [31:0] IF_ID_inst,
    output logic        IF_ID_vld
);

    localparam int PQ_AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int FF_AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0] PQ_LIMIT = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] FF_LIMIT = CNT_W'(FIFO_DEPTH);
    localparam logic [PQ_AW-1:0] PQ_LAST  = PQ_AW'(MAX_OUTSTANDING - 1);
    localparam logic [FF_AW-1:0] FF_LAST  = FF_AW'(FIFO_DEPTH - 1);
    localparam logic [31:0]      NOP_INST = 32'h0000_0013;

    // Circular pointer advance for the PC queue.
    function automatic logic [PQ_AW-1:0] pq_next(input logic [PQ_AW-1:0] p);
        return (p == PQ_LAST) ? '0 : p + 1'b1;
    endfunction

    // Circular pointer advance for the instruction buffer.
    function automatic logic [FF_AW-1:0] ff_next(input logic [FF_AW-1:0] p);
        return (p == FF_LAST) ? '0 : p + 1'b1;
    endfunction

    // Fetch address
    logic [31:0] fetch_pc_q, fetch_pc_d;

    // PC queue: one entry per granted request awaiting its response
    logic [31:0]                pcq_pc_q    [MAX_OUTSTANDING];
    logic [31:0]                pcq_pc_d    [MAX_OUTSTANDING];
    logic [MAX_OUTSTANDING-1:0] pcq_stale_q, pcq_stale_d;
    logic [PQ_AW-1:0]           pcq_rd_q,    pcq_rd_d;
    logic [PQ_AW-1:0]           pcq_wr_q,    pcq_wr_d;
    logic [CNT_W-1:0]           pcq_cnt_q,   pcq_cnt_d;

    // Instruction buffer holding {pc, inst} pairs while decode is busy
    logic [31:0]      fifo_pc_q   [FIFO_DEPTH];
    logic [31:0]      fifo_pc_d   [FIFO_DEPTH];
    logic [31:0]      fifo_inst_q [FIFO_DEPTH];
    logic [31:0]      fifo_inst_d [FIFO_DEPTH];
    logic [FF_AW-1:0] fifo_rd_q,  fifo_rd_d;
    logic [FF_AW-1:0] fifo_wr_q,  fifo_wr_d;
    logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;

    // IF/ID output register
    logic [31:0] if_id_pc_q,   if_id_pc_d;
    logic [31:0] if_id_inst_q, if_id_inst_d;
    logic        if_id_vld_q,  if_id_vld_d;

    // Per-cycle events
    logic        grant;
    logic        pcq_pop;
    logic        head_stale;
    logic [31:0] head_pc;
    logic        deliver;
    logic        fifo_pop;
    logic        bypass;
    logic        fifo_push;

    // Request only with credit: every in-flight request (stale or not) must
    // have a guaranteed buffer slot, so a stalled decode can never lose data.
    // Reset gates the request directly so it drops without waiting for a clock.
    always_comb begin
        imem_req = rst && !EX_redirect
                && (pcq_cnt_q < PQ_LIMIT)
                && ((pcq_cnt_q + fifo_cnt_q) < FF_LIMIT);
    end

    assign imem_addr = fetch_pc_q;

    // Decode this cycle's grant / response / buffer movements.
    always_comb begin
        grant      = imem_req && imem_gnt;
        pcq_pop    = imem_rvalid && (pcq_cnt_q != '0);
        head_stale = pcq_stale_q[pcq_rd_q];
        head_pc    = pcq_pc_q[pcq_rd_q];
        deliver    = pcq_pop && !head_stale && !EX_redirect;
        fifo_pop   = !EX_redirect && !ID_stall && (fifo_cnt_q != '0);
        bypass     = !EX_redirect && !ID_stall && (fifo_cnt_q == '0) && deliver;
        fifo_push  = deliver && !bypass;
    end

    // Next fetch address: redirect target (word aligned) or sequential step.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (EX_redirect) begin
            fetch_pc_d = EX_target & 32'hFFFF_FFFC;
        end else if (grant) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
    end

    // PC queue push on grant, pop on response; a redirect poisons every entry.
    always_comb begin
        pcq_pc_d    = pcq_pc_q;
        pcq_stale_d = pcq_stale_q;
        pcq_rd_d    = pcq_rd_q;
        pcq_wr_d    = pcq_wr_q;
        pcq_cnt_d   = pcq_cnt_q;

        if (grant) begin
            pcq_pc_d[pcq_wr_q]    = fetch_pc_q;
            pcq_stale_d[pcq_wr_q] = 1'b0;
            pcq_wr_d              = pq_next(pcq_wr_q);
        end
        if (pcq_pop) begin
            pcq_rd_d = pq_next(pcq_rd_q);
        end

        case ({grant, pcq_pop})
            2'b10:   pcq_cnt_d = pcq_cnt_q + 1'b1;
            2'b01:   pcq_cnt_d = pcq_cnt_q - 1'b1;
            default: pcq_cnt_d = pcq_cnt_q;
        endcase

        // Unused slots are marked too; a later grant clears its own bit.
        if (EX_redirect) begin
            pcq_stale_d = '1;
        end
    end

    // Instruction buffer: write responses decode cannot take now, read when
    // decode is free; a redirect empties it.
    always_comb begin
        fifo_pc_d   = fifo_pc_q;
        fifo_inst_d = fifo_inst_q;
        fifo_rd_d   = fifo_rd_q;
        fifo_wr_d   = fifo_wr_q;
        fifo_cnt_d  = fifo_cnt_q;

        if (EX_redirect) begin
            fifo_rd_d  = '0;
            fifo_wr_d  = '0;
            fifo_cnt_d = '0;
        end else begin
            if (fifo_push) begin
                fifo_pc_d[fifo_wr_q]   = head_pc;
                fifo_inst_d[fifo_wr_q] = imem_rdata;
                fifo_wr_d              = ff_next(fifo_wr_q);
            end
            if (fifo_pop) begin
                fifo_rd_d = ff_next(fifo_rd_q);
            end
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
                2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
                default: fifo_cnt_d = fifo_cnt_q;
            endcase
        end
    end

    // IF/ID update: buffered instructions go first to keep program order,
    // otherwise a fresh response bypasses straight into the register.
    always_comb begin
        if_id_pc_d   = if_id_pc_q;
        if_id_inst_d = if_id_inst_q;
        if_id_vld_d  = if_id_vld_q;

        if (EX_redirect) begin
            if_id_vld_d = 1'b0;
        end else if (!ID_stall) begin
            if (fifo_pop) begin
                if_id_pc_d   = fifo_pc_q[fifo_rd_q];
                if_id_inst_d = fifo_inst_q[fifo_rd_q];
                if_id_vld_d  = 1'b1;
            end else if (bypass) begin
                if_id_pc_d   = head_pc;
                if_id_inst_d = imem_rdata;
                if_id_vld_d  = 1'b1;
            end else begin
                if_id_vld_d  = 1'b0;
            end
        end
    end

    // Control state and the IF/ID bundle, cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q   <= RESET_PC;
            pcq_stale_q  <= '0;
            pcq_rd_q     <= '0;
            pcq_wr_q     <= '0;
            pcq_cnt_q    <= '0;
            fifo_rd_q    <= '0;
            fifo_wr_q    <= '0;
            fifo_cnt_q   <= '0;
            if_id_pc_q   <= 32'h0000_0000;
            if_id_inst_q <= NOP_INST;
            if_id_vld_q  <= 1'b0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            pcq_stale_q  <= pcq_stale_d;
            pcq_rd_q     <= pcq_rd_d;
            pcq_wr_q     <= pcq_wr_d;
            pcq_cnt_q    <= pcq_cnt_d;
            fifo_rd_q    <= fifo_rd_d;
            fifo_wr_q    <= fifo_wr_d;
            fifo_cnt_q   <= fifo_cnt_d;
            if_id_pc_q   <= if_id_pc_d;
            if_id_inst_q <= if_id_inst_d;
            if_id_vld_q  <= if_id_vld_d;
        end
    end

    // Queue and buffer payloads; only meaningful while their counters cover them.
    always_ff @(posedge clk) begin
        pcq_pc_q    <= pcq_pc_d;
        fifo_pc_q   <= fifo_pc_d;
        fifo_inst_q <= fifo_inst_d;
    end

    assign IF_ID_pc   = if_id_pc_q;
    assign IF_ID_inst = if_id_inst_q;
    assign IF_ID_vld  = if_id_vld_q;

    // A response with nothing in flight is a memory protocol violation.
    a_rvalid_has_request : assert property (@(posedge clk) disable iff (!rst)
        !(imem_rvalid && (pcq_cnt_q == '0)));

    // Credit must keep the buffer from ever overflowing.
    a_fifo_no_overflow : assert property (@(posedge clk) disable iff (!rst)
        !(fifo_push && !fifo_pop && (fifo_cnt_q == FF_LIMIT)));

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: a behavioural fetch model built from queues, a simple
// in-order memory responder, directed scenarios and a randomized soak.
module tb_if_stage;

    localparam int          MAXO = 2;
    localparam int          FD   = 2;
    localparam logic [31:0] RPC  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt    = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata  = 32'h0;
    logic        ID_stall    = 1'b0;
    logic        EX_redirect = 1'b0;
    logic [31:0] EX_target   = 32'h0;
    logic [31:0] IF_ID_pc;
    logic [31:0] IF_ID_inst;
    logic        IF_ID_vld;

    if_stage #(.RESET_PC(RPC), .MAX_OUTSTANDING(MAXO), .FIFO_DEPTH(FD)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .ID_stall   (ID_stall),
        .EX_redirect(EX_redirect),
        .EX_target  (EX_target),
        .IF_ID_pc   (IF_ID_pc),
        .IF_ID_inst (IF_ID_inst),
        .IF_ID_vld  (IF_ID_vld)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [31:0] pc;
        logic        stale;
    } pq_t;

    pq_t         m_pcq[$];
    logic [63:0] m_fifo[$];
    logic [31:0] m_fetch;
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    logic        m_vld;
    logic        m_req;

    function automatic void model_reset();
        m_pcq.delete();
        m_fifo.delete();
        m_fetch = RPC;
        m_pc    = 32'h0;
        m_inst  = 32'h0000_0013;
        m_vld   = 1'b0;
    endfunction

    function automatic void model_update(logic push, logic rv, logic [31:0] rdata,
                                         logic stall, logic redir, logic [31:0] tgt);
        logic        deliver;
        logic [31:0] rpc;
        pq_t         h;
        pq_t         e;
        deliver = 1'b0;
        rpc     = 32'h0;
        if (rv && m_pcq.size() > 0) begin
            h       = m_pcq.pop_front();
            deliver = !h.stale && !redir;
            rpc     = h.pc;
        end
        if (redir) begin
            foreach (m_pcq[i]) m_pcq[i].stale = 1'b1;
            m_fifo.delete();
            m_vld   = 1'b0;
            m_fetch = {tgt[31:2], 2'b00};
        end else begin
            if (!stall) begin
                if (m_fifo.size() > 0) begin
                    {m_pc, m_inst} = m_fifo.pop_front();
                    m_vld = 1'b1;
                    if (deliver) m_fifo.push_back({rpc, rdata});
                end else if (deliver) begin
                    m_pc   = rpc;
                    m_inst = rdata;
                    m_vld  = 1'b1;
                end else begin
                    m_vld = 1'b0;
                end
            end else if (deliver) begin
                m_fifo.push_back({rpc, rdata});
            end
            if (push) begin
                e.pc    = m_fetch;
                e.stale = 1'b0;
                m_pcq.push_back(e);
                m_fetch = m_fetch + 32'd4;
            end
        end
    endfunction

    // ---------------- stimulus controls / memory ----------------
    int          mq[$];          // due cycle of each outstanding request, in order
    int          cyc = 0;
    int          gnt_mode = 1;   // 0 never, 1 always, 2 random, 3 toggle
    int          lat_lo = 1;
    int          lat_hi = 1;
    int          p_stall = 0;
    int          p_redir = 0;
    logic        mem_hold = 1'b0;
    logic        tog = 1'b0;
    logic        force_stall = 1'b0;
    logic        force_redir = 1'b0;
    logic [31:0] force_tgt = 32'h0;
    logic        redir_on_rv = 1'b0;
    logic        d_hit = 1'b0;
    logic        last_req;
    logic        last_grant;
    logic [31:0] last_addr;
    int          first_gnt = -1;
    int          first_vld = -1;
    logic        seq_on = 1'b0;
    logic [31:0] seq_exp = 32'h0;

    // One clock cycle: drive at the falling edge, check combinational outputs,
    // advance model and memory at the rising edge, check registered outputs.
    task automatic step();
        logic        rv, g, st, rd;
        logic [31:0] tg, rdat;
        int          lat;
        rv = rst && !mem_hold && (mq.size() > 0);
        if (rv) rv = (mq[0] <= cyc);
        case (gnt_mode)
            0:       g = 1'b0;
            1:       g = 1'b1;
            2:       g = 1'($urandom_range(1));
            default: begin g = tog; tog = !tog; end
        endcase
        st = force_stall || (int'($urandom_range(99)) < p_stall);
        rd = force_redir || (int'($urandom_range(99)) < p_redir);
        tg = force_redir ? force_tgt : $urandom;
        if (redir_on_rv && rv) begin
            rd = 1'b1;
            st = 1'b1;
            redir_on_rv = 1'b0;
            d_hit = 1'b1;
        end
        rdat = $urandom;
        imem_gnt    = g;
        imem_rvalid = rv;
        imem_rdata  = rdat;
        ID_stall    = st;
        EX_redirect = rd;
        EX_target   = tg;
        #1;
        m_req = rst && !rd && (m_pcq.size() < MAXO) && ((m_pcq.size() + m_fifo.size()) < FD);
        chk("imem_req", 32'(imem_req), 32'(m_req));
        chk("imem_addr", imem_addr, m_fetch);
        last_req   = imem_req;
        last_addr  = imem_addr;
        last_grant = imem_req && g;
        if (first_gnt < 0 && last_grant) first_gnt = cyc;
        if (first_vld < 0 && IF_ID_vld) first_vld = cyc;
        @(posedge clk);
        if (rst) begin
            if (rv) void'(mq.pop_front());
            if (last_grant) begin
                lat = int'($urandom_range(lat_hi, lat_lo));
                mq.push_back(cyc + lat);
            end
            model_update(m_req && g, rv, rdat, st, rd, tg);
        end
        cyc++;
        #1;
        chk("IF_ID_vld", 32'(IF_ID_vld), 32'(m_vld));
        chk("IF_ID_pc", IF_ID_pc, m_pc);
        chk("IF_ID_inst", IF_ID_inst, m_inst);
        chk("outstanding_le_max", 32'(mq.size() <= MAXO), 32'd1);
        if (seq_on && !st && !rd && IF_ID_vld) begin
            chk("seq_pc", IF_ID_pc, seq_exp);
            seq_exp = seq_exp + 32'd4;
        end
        @(negedge clk);
    endtask

    // Assert reset in the middle of a cycle and check it acts at once.
    task automatic do_reset(int cycles);
        #2 rst = 1'b0;
        #1;
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_IF_ID_vld", 32'(IF_ID_vld), 32'd0);
        chk("rst_IF_ID_pc", IF_ID_pc, 32'h0);
        chk("rst_IF_ID_inst", IF_ID_inst, 32'h0000_0013);
        model_reset();
        mq.delete();
        @(negedge clk);
        repeat (cycles) step();
        rst = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cnt;
        model_reset();

        // Reset release, grant every cycle, 1-cycle latency, no stall
        do_reset(3);
        first_gnt = -1;
        first_vld = -1;
        seq_exp   = 32'h0;
        seq_on    = 1'b1;
        repeat (10) step();
        chk("first_vld_latency", 32'(first_vld - first_gnt), 32'd2);

        // Five-cycle decode stall mid-stream
        force_stall = 1'b1;
        repeat (5) step();
        chk("stall_req_dropped", 32'(last_req), 32'd0);
        chk("stall_hold_vld", 32'(IF_ID_vld), 32'd1);
        chk("stall_hold_pc", IF_ID_pc, seq_exp - 32'd4);
        force_stall = 1'b0;
        cnt = 0;
        repeat (8) begin
            step();
            if (IF_ID_vld) cnt++;
        end
        chk("stall_release_no_gap", 32'(cnt), 32'd8);
        seq_on = 1'b0;

        // Redirect with 0x10 and 0x14 outstanding
        do_reset(2);
        n = 0;
        while (imem_addr !== 32'h10 && n < 50) begin
            step();
            n++;
        end
        chk("reach_0x10", imem_addr, 32'h10);
        gnt_mode = 0;
        repeat (3) step();
        mem_hold = 1'b1;
        gnt_mode = 1;
        repeat (3) step();
        chk("two_outstanding", 32'(mq.size()), 32'd2);
        chk("addr_after_two", imem_addr, 32'h18);
        force_redir = 1'b1;
        force_tgt   = 32'h0000_0103;
        step();
        force_redir = 1'b0;
        chk("redir_req_low", 32'(last_req), 32'd0);
        chk("redir_addr", imem_addr, 32'h100);
        chk("redir_vld_low", 32'(IF_ID_vld), 32'd0);
        mem_hold = 1'b0;
        n = 0;
        while (!IF_ID_vld && n < 30) begin
            step();
            n++;
        end
        chk("redir_first_pc", IF_ID_pc, 32'h100);

        // Redirect in the same cycle as a response, with decode stalled
        lat_lo = 2;
        lat_hi = 2;
        d_hit = 1'b0;
        redir_on_rv = 1'b1;
        n = 0;
        while (!d_hit && n < 20) begin
            step();
            n++;
        end
        redir_on_rv = 1'b0;
        chk("rv_redir_hit", 32'(d_hit), 32'd1);
        chk("rv_redir_req_low", 32'(last_req), 32'd0);
        chk("rv_redir_vld_low", 32'(IF_ID_vld), 32'd0);

        // 3-cycle latency with grant toggling
        gnt_mode = 3;
        lat_lo = 3;
        lat_hi = 3;
        repeat (60) step();

        // Address wrap at the top of memory, then async reset mid-cycle
        gnt_mode = 1;
        lat_lo = 1;
        lat_hi = 1;
        force_redir = 1'b1;
        force_tgt   = 32'hFFFF_FFFF;
        step();
        force_redir = 1'b0;
        chk("wrap_redirect_aligned", imem_addr, 32'hFFFF_FFFC);
        n = 0;
        last_grant = 1'b0;
        while (!(last_grant && last_addr == 32'hFFFF_FFFC) && n < 20) begin
            step();
            n++;
        end
        chk("wrap_next_addr", imem_addr, 32'h0000_0000);
        repeat (4) step();
        chk("pre_rst_vld", 32'(IF_ID_vld), 32'd1);
        chk("pre_rst_req", 32'(imem_req), 32'd1);
        do_reset(2);

        // Randomized soak with a reset in the middle
        gnt_mode = 2;
        lat_lo = 1;
        lat_hi = 4;
        p_stall = 25;
        p_redir = 4;
        repeat (2000) step();
        do_reset(2);
        repeat (1500) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
